// File: rtl/poly_note_player_if.sv
// poly_note_player_if
// Bundles the song-reader request, beat/codec strobes and the player's
// status/mix outputs into one port so the player and its driver agree on
// widths in one place.
//
// Modports:
//   master - the song reader / sequencer side. It drives play_enable,
//            load_new_note, note_to_load, duration, beat and
//            generate_next_sample, and observes all player outputs.
//   slave  - the poly_note_player side.
//
// Signals:
//   play_enable          run (1) / freeze (0)
//   load_new_note        one-cycle load request
//   note_to_load         note index for the request (0 = rest)
//   duration             beats for the request (0 is illegal)
//   beat                 one-cycle beat tick
//   generate_next_sample codec sample request
//   load_accepted        pulse: request placed in a voice
//   load_dropped         pulse: request discarded
//   voice_busy           per-voice active flags
//   note_done            per-voice pulse when its duration expires
//   sample_out           signed mixed sample, MIX_W bits
//   sample_ready         pulse: sample_out updated
interface poly_note_player_if #(
   parameter int VOICES   = 3,
   parameter int NOTE_W   = 6,
   parameter int DUR_W    = 6,
   parameter int SAMPLE_W = 16,
   parameter int MIX_W    = SAMPLE_W + $clog2(VOICES)
);
   logic                    play_enable;
   logic                    load_new_note;
   logic [NOTE_W-1:0]       note_to_load;
   logic [DUR_W-1:0]        duration;
   logic                    beat;
   logic                    generate_next_sample;
   logic                    load_accepted;
   logic                    load_dropped;
   logic [VOICES-1:0]       voice_busy;
   logic [VOICES-1:0]       note_done;
   logic signed [MIX_W-1:0] sample_out;
   logic                    sample_ready;

   modport master (
      output play_enable, load_new_note, note_to_load, duration, beat,
             generate_next_sample,
      input  load_accepted, load_dropped, voice_busy, note_done, sample_out,
             sample_ready
   );

   modport slave (
      input  play_enable, load_new_note, note_to_load, duration, beat,
             generate_next_sample,
      output load_accepted, load_dropped, voice_busy, note_done, sample_out,
             sample_ready
   );
endinterface

// File: rtl/poly_note_player.sv
// poly_note_player
// Polyphonic note player. Load requests are placed in the lowest-index idle
// voice, each voice counts its duration down on qualifying beats, and all
// voice samples are summed into one widened signed sample.
//
// Contains the per-voice helpers:
//   frequency_rom - registered note -> phase step lookup (step = note << 8)
//   sine_reader   - 16-bit phase accumulator driving a 16-entry sine table;
//                   SAMPLE_W must be 2..16 (the table is 16-bit and the
//                   sample is its top SAMPLE_W bits)
//
// poly_note_player ports:
//   clk    system clock
//   reset  synchronous, active-high; clears all state
//   bus    poly_note_player_if.slave (see the interface file)
//
// Optional feature macro: VOICE_STEAL_EN. When defined, a legal request
// arriving while every voice is busy steals the busy voice with the smallest
// remaining count (lowest index on ties). Undefined: such requests are dropped.

module frequency_rom #(
   parameter int NOTE_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NOTE_W-1:0] address,
   output logic [15:0]       step_size
);
   // One-cycle registered lookup; note 0 is a rest and yields step 0.
   always_ff @(posedge clk) begin
      if (reset) step_size <= '0;
      else       step_size <= 16'({address, 8'h00});
   end
endmodule

module sine_reader #(
   parameter int SAMPLE_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       generate_next,
   input  logic [15:0]                step_size,
   output logic signed [SAMPLE_W-1:0] sample,
   output logic                       sample_ready
);
   logic [15:0]        phase;
   logic [15:0]        phase_next;
   logic signed [15:0] next_entry;

   function automatic logic signed [15:0] sine_entry(input logic [3:0] idx);
      case (idx)
         4'd0:  sine_entry = 16'sd0;
         4'd1:  sine_entry = 16'sd12539;
         4'd2:  sine_entry = 16'sd23170;
         4'd3:  sine_entry = 16'sd30273;
         4'd4:  sine_entry = 16'sd32767;
         4'd5:  sine_entry = 16'sd30273;
         4'd6:  sine_entry = 16'sd23170;
         4'd7:  sine_entry = 16'sd12539;
         4'd8:  sine_entry = 16'sd0;
         4'd9:  sine_entry = -16'sd12539;
         4'd10: sine_entry = -16'sd23170;
         4'd11: sine_entry = -16'sd30273;
         4'd12: sine_entry = -16'sd32767;
         4'd13: sine_entry = -16'sd30273;
         4'd14: sine_entry = -16'sd23170;
         default: sine_entry = -16'sd12539;
      endcase
   endfunction

   assign phase_next = phase + step_size;
   assign next_entry = sine_entry(phase_next[15:12]);

   // Each request advances the phase and looks up the new phase, so the
   // sample and its ready pulse appear the cycle after the request.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase        <= '0;
         sample       <= '0;
         sample_ready <= 1'b0;
      end else begin
         sample_ready <= generate_next;
         if (generate_next) begin
            phase  <= phase_next;
            sample <= next_entry[15 -: SAMPLE_W];
         end
      end
   end
endmodule

module poly_note_player #(
   parameter int VOICES   = 3,
   parameter int NOTE_W   = 6,
   parameter int DUR_W    = 6,
   parameter int SAMPLE_W = 16
) (
   input logic               clk,
   input logic               reset,
   poly_note_player_if.slave bus
);
   localparam int MIX_W = SAMPLE_W + $clog2(VOICES);
   localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

   typedef enum logic {IDLE, ACTIVE} voice_state_t;

   voice_state_t            state [VOICES];
   logic [NOTE_W-1:0]       note  [VOICES];
   logic [DUR_W-1:0]        count [VOICES];
   logic [VOICES-1:0]       busy;
   logic [VOICES-1:0]       done_q;
   logic                    accepted_q;
   logic                    dropped_q;

   logic [IDX_W-1:0]        target;
   logic                    have_target;
   logic                    steal;
   logic                    legal;
   logic [DUR_W-1:0]        best_count;

   logic                    generate_next;
   logic [15:0]             step [VOICES];
   logic signed [SAMPLE_W-1:0] voice_sample [VOICES];
   logic [VOICES-1:0]       voice_ready;
   logic signed [MIX_W-1:0] mix_sum;
   logic signed [MIX_W-1:0] sample_q;
   logic                    ready_q;

   assign legal         = bus.load_new_note & bus.play_enable & (bus.duration != '0);
   assign generate_next = bus.play_enable & bus.generate_next_sample;

   // Busy flags come straight from the registered voice states.
   always_comb begin
      busy = '0;
      for (int i = 0; i < VOICES; i++) busy[i] = (state[i] == ACTIVE);
   end

   // Pick the lowest-index idle voice. A voice expiring this cycle is still
   // ACTIVE here, so it is never chosen. With stealing, a full player picks
   // the smallest count instead; strict '<' keeps the lowest index on ties.
   always_comb begin
      target      = '0;
      have_target = 1'b0;
      steal       = 1'b0;
      best_count  = count[0];
      for (int i = VOICES - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            target      = IDX_W'(i);
            have_target = 1'b1;
         end
      end
`ifdef VOICE_STEAL_EN
      if (!have_target) begin
         steal       = 1'b1;
         have_target = 1'b1;
         for (int i = 1; i < VOICES; i++) begin
            if (count[i] < best_count) begin
               best_count = count[i];
               target     = IDX_W'(i);
            end
         end
      end
`endif
   end

   // Voice state machine. A load into a voice takes priority over that
   // voice's beat decrement; a stolen voice reports note_done as it reloads.
   // With play_enable low nothing moves and no pulses are produced, though a
   // request is still reported as dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < VOICES; i++) begin
            state[i] <= IDLE;
            note[i]  <= '0;
            count[i] <= '0;
         end
         done_q     <= '0;
         accepted_q <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         done_q     <= '0;
         accepted_q <= legal & have_target;
         dropped_q  <= bus.load_new_note & ~(legal & have_target);
         if (bus.play_enable) begin
            for (int i = 0; i < VOICES; i++) begin
               if (legal && have_target && target == IDX_W'(i)) begin
                  state[i]  <= ACTIVE;
                  note[i]   <= bus.note_to_load;
                  count[i]  <= bus.duration;
                  done_q[i] <= steal;
               end else if (bus.beat && state[i] == ACTIVE) begin
                  count[i] <= count[i] - 1'b1;
                  if (count[i] == DUR_W'(1)) begin
                     state[i]  <= IDLE;
                     done_q[i] <= 1'b1;
                  end
               end
            end
         end
      end
   end

   // Idle voices address the rest entry so their step is zero.
   for (genvar g = 0; g < VOICES; g++) begin : g_voice
      logic [NOTE_W-1:0] rom_address;
      assign rom_address = busy[g] ? note[g] : '0;

      frequency_rom #(.NOTE_W(NOTE_W)) u_rom (
         .clk       (clk),
         .reset     (reset),
         .address   (rom_address),
         .step_size (step[g])
      );

      sine_reader #(.SAMPLE_W(SAMPLE_W)) u_reader (
         .clk           (clk),
         .reset         (reset),
         .generate_next (generate_next),
         .step_size     (step[g]),
         .sample        (voice_sample[g]),
         .sample_ready  (voice_ready[g])
      );
   end

   // Sign-extend and sum the busy voices; MIX_W covers the worst case so the
   // sum never wraps.
   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < VOICES; i++) begin
         if (busy[i]) mix_sum = mix_sum + MIX_W'(voice_sample[i]);
      end
   end

   // Every reader sees the same request, so their ready pulses coincide with
   // voice 0's; the AND is simply voice 0's strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (bus.play_enable && (&voice_ready)) begin
            sample_q <= mix_sum;
            ready_q  <= 1'b1;
         end
      end
   end

   assign bus.load_accepted = accepted_q;
   assign bus.load_dropped  = dropped_q;
   assign bus.voice_busy    = busy;
   assign bus.note_done     = done_q;
   assign bus.sample_out    = sample_q;
   assign bus.sample_ready  = ready_q;
endmodule

// File: tb/tb_poly_note_player.sv
// tb_poly_note_player
// Directed bench for poly_note_player with VOICES=3. Stimulus is a linear
// sequence of steps; expected values are hand-derived (step = note << 8,
// sine table index = top 4 phase bits).
module tb_poly_note_player;
   localparam int VOICES   = 3;
   localparam int NOTE_W   = 6;
   localparam int DUR_W    = 6;
   localparam int SAMPLE_W = 16;

   logic clk = 1'b0;
   logic reset;
   int   testsRun    = 0;
   int   testsFailed = 0;

   poly_note_player_if #(
      .VOICES(VOICES), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .SAMPLE_W(SAMPLE_W)
   ) bus ();

   poly_note_player #(
      .VOICES(VOICES), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .SAMPLE_W(SAMPLE_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs, take the edge, then drop the pulse inputs.
   task automatic applyStimulus(input logic load, input logic [NOTE_W-1:0] noteIn,
                                input logic [DUR_W-1:0] durIn, input logic beatIn,
                                input logic genIn);
      bus.load_new_note        = load;
      bus.note_to_load         = noteIn;
      bus.duration             = durIn;
      bus.beat                 = beatIn;
      bus.generate_next_sample = genIn;
      tick();
      bus.load_new_note        = 1'b0;
      bus.note_to_load         = '0;
      bus.duration             = '0;
      bus.beat                 = 1'b0;
      bus.generate_next_sample = 1'b0;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset                    = 1'b1;
      bus.play_enable          = 1'b1;
      bus.load_new_note        = 1'b0;
      bus.note_to_load         = '0;
      bus.duration             = '0;
      bus.beat                 = 1'b0;
      bus.generate_next_sample = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      checkOutput("rst_busy", bus.voice_busy, 0);
      checkOutput("rst_sample", bus.sample_out, 0);
      checkOutput("rst_ready", bus.sample_ready, 0);
      checkOutput("rst_done", bus.note_done, 0);
      checkOutput("rst_accepted", bus.load_accepted, 0);
      checkOutput("rst_dropped", bus.load_dropped, 0);

      // Single note, duration 3
      applyStimulus(1'b1, 6'd20, 6'd3, 1'b0, 1'b0);
      checkOutput("t1_accepted", bus.load_accepted, 1);
      checkOutput("t1_dropped", bus.load_dropped, 0);
      checkOutput("t1_busy", bus.voice_busy, 3'b001);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("t1_accepted_pulse", bus.load_accepted, 0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      checkOutput("t1_busy_beat2", bus.voice_busy, 3'b001);
      checkOutput("t1_done_beat2", bus.note_done, 0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      checkOutput("t1_done_beat3", bus.note_done, 3'b001);
      checkOutput("t1_busy_beat3", bus.voice_busy, 0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("t1_done_pulse", bus.note_done, 0);

      // Four back-to-back loads into three voices
      applyStimulus(1'b1, 6'd1, 6'd10, 1'b0, 1'b0);
      checkOutput("t2_busy1", bus.voice_busy, 3'b001);
      applyStimulus(1'b1, 6'd2, 6'd10, 1'b0, 1'b0);
      checkOutput("t2_busy2", bus.voice_busy, 3'b011);
      applyStimulus(1'b1, 6'd3, 6'd10, 1'b0, 1'b0);
      checkOutput("t2_busy3", bus.voice_busy, 3'b111);
      checkOutput("t2_accepted3", bus.load_accepted, 1);
      applyStimulus(1'b1, 6'd4, 6'd10, 1'b0, 1'b0);
      checkOutput("t2_busy4", bus.voice_busy, 3'b111);
`ifdef VOICE_STEAL_EN
      checkOutput("t2_steal_accepted", bus.load_accepted, 1);
      checkOutput("t2_steal_dropped", bus.load_dropped, 0);
      checkOutput("t2_steal_done", bus.note_done, 3'b001);
`else
      checkOutput("t2_full_dropped", bus.load_dropped, 1);
      checkOutput("t2_full_accepted", bus.load_accepted, 0);
      checkOutput("t2_full_done", bus.note_done, 0);
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("t2_rst_busy", bus.voice_busy, 0);

      // Zero-duration request
      applyStimulus(1'b1, 6'd7, 6'd5, 1'b0, 1'b0);
      checkOutput("t3_busy", bus.voice_busy, 3'b001);
      applyStimulus(1'b1, 6'd5, 6'd0, 1'b0, 1'b0);
      checkOutput("t3_dropped", bus.load_dropped, 1);
      checkOutput("t3_accepted", bus.load_accepted, 0);
      checkOutput("t3_busy_hold", bus.voice_busy, 3'b001);

      // Load coinciding with a beat while voice 1 sits at count 1
      applyStimulus(1'b1, 6'd8, 6'd1, 1'b0, 1'b0);
      checkOutput("t4_busy_setup", bus.voice_busy, 3'b011);
      applyStimulus(1'b1, 6'd9, 6'd4, 1'b1, 1'b0);
      checkOutput("t4_accepted", bus.load_accepted, 1);
      checkOutput("t4_done_v1", bus.note_done, 3'b010);
      checkOutput("t4_busy", bus.voice_busy, 3'b101);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      checkOutput("t4_busy_b3", bus.voice_busy, 3'b101);
      checkOutput("t4_done_b3", bus.note_done, 0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      checkOutput("t4_done_b4", bus.note_done, 3'b101);
      checkOutput("t4_busy_b4", bus.voice_busy, 0);

      // Freeze with play_enable low
      applyStimulus(1'b1, 6'd0, 6'd2, 1'b0, 1'b0);
      checkOutput("t6_busy", bus.voice_busy, 3'b001);
      bus.play_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
         checkOutput("t6_frozen_done", bus.note_done, 0);
      end
      checkOutput("t6_frozen_busy", bus.voice_busy, 3'b001);
      checkOutput("t6_frozen_ready", bus.sample_ready, 0);
      applyStimulus(1'b1, 6'd3, 6'd4, 1'b0, 1'b0);
      checkOutput("t6_frozen_dropped", bus.load_dropped, 1);
      checkOutput("t6_frozen_accepted", bus.load_accepted, 0);
      checkOutput("t6_frozen_busy2", bus.voice_busy, 3'b001);
      bus.play_enable = 1'b1;
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      checkOutput("t6_resume_busy", bus.voice_busy, 3'b001);
      checkOutput("t6_resume_done", bus.note_done, 0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      checkOutput("t6_resume_done2", bus.note_done, 3'b001);
      checkOutput("t6_resume_busy2", bus.voice_busy, 0);

      // Two rests plus one tone (note 20, step 0x1400)
      applyStimulus(1'b1, 6'd0, 6'd20, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'd0, 6'd20, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'd20, 6'd20, 1'b0, 1'b0);
      checkOutput("t5_busy", bus.voice_busy, 3'b111);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput("t5_ready_lag", bus.sample_ready, 0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("t5_ready1", bus.sample_ready, 1);
      checkOutput("t5_sample1", bus.sample_out, 32'd12539);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("t5_ready_pulse", bus.sample_ready, 0);
      checkOutput("t5_sample_hold", bus.sample_out, 32'd12539);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("t5_sample2", bus.sample_out, 32'd23170);
      for (int k = 3; k <= 8; k++) begin
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      end
      checkOutput("t5_sample8_neg", bus.sample_out, -32'sd23170);

      // Reset during active notes
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("t7_busy", bus.voice_busy, 0);
      checkOutput("t7_done", bus.note_done, 0);
      checkOutput("t7_sample", bus.sample_out, 0);
      checkOutput("t7_ready", bus.sample_ready, 0);
      checkOutput("t7_accepted", bus.load_accepted, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/poly_note_player.md
# poly_note_player

Parametrised polyphonic note player: accepts note/duration load requests from the song reader, allocates each to an idle voice, times each voice's duration in beats, and mixes all voice samples into one widened sample for the codec path. Each voice owns a `frequency_rom` and a `sine_reader`. The block replaces the fixed three-voice player and adds full-voice handling, per-voice status, and a single mixed output.

## Interface
Parameters:
- `VOICES`, 3: number of voices, 1..8.
- `NOTE_W`, 6: note index width. Note 0 is a rest, with step size 0.
- `DUR_W`, 6: duration width, in beats.
- `SAMPLE_W`, 16: signed per-voice sample width from `sine_reader`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; clears all state
- `play_enable`  in  1  high = run; low = freeze counters and sample generation
- `load_new_note`  in  1  one-cycle load request
- `note_to_load`  in  NOTE_W  note index for the request
- `duration`  in  DUR_W  beats for the request; 0 is illegal
- `beat`  in  1  one-cycle 1/48 s tick
- `generate_next_sample`  in  1  codec sample request
- `load_accepted`  out  1  pulse: request was placed in a voice
- `load_dropped`  out  1  pulse: request was discarded
- `voice_busy`  out  VOICES  per-voice active flag
- `note_done`  out  VOICES  per-voice pulse when its duration expires
- `sample_out`  out  SAMPLE_W+$clog2(VOICES)  signed mixed sample
- `sample_ready`  out  1  pulse: `sample_out` updated

## Operation
- Each voice is either IDLE or ACTIVE. Each voice holds registers `note[NOTE_W]` and `count[DUR_W]`.
- Allocation happens on a cycle with `load_new_note=1`, `play_enable=1` and `duration!=0`:
  - The lowest-index IDLE voice is chosen.
  - It loads `note` and `count=duration` and goes ACTIVE.
  - `load_accepted` pulses for one cycle.
- `load_dropped` pulses instead when any of these holds:
  - `duration==0`.
  - `play_enable=0`.
  - No voice is IDLE (unless VOICE_STEAL_EN; see Configuration).
- Countdown: on `beat` with `play_enable=1`, every ACTIVE voice that is not being loaded this cycle decrements `count`.
  - When a voice decrements from 1 to 0, it goes IDLE and pulses its `note_done` bit.
- Load and beat in the same cycle: the load wins for the target voice, so its count becomes `duration` with no decrement. Other voices still decrement.
- A voice that expires and a load in the same cycle: the expiring voice is not IDLE until the next cycle, so it is not eligible for allocation.
- Sine generation:
  - Each `sine_reader` gets `generate_next = play_enable & generate_next_sample`.
  - An IDLE voice's `frequency_rom` address is forced to 0.
- Mixing:
  - Each voice's sample is sign-extended to the mix width; IDLE voices contribute 0.
  - The sum is never saturated, because the width is sized for the worst case.
  - The sum is registered on voice 0's `sine_reader` `sample_ready`; all readers share the same request, so they are aligned.
- `play_enable=0`:
  - Counts, states and `sample_out` hold.
  - No `sample_ready`, `note_done` or `load_accepted` pulses are produced.
- Reset values:
  - All voices IDLE, counts 0, notes 0.
  - `sample_out=0`.
  - All pulse outputs 0.
  - `voice_busy=0`.

## Timing
- Load request in cycle t → `load_accepted`/`load_dropped` registered, high in t+1. `voice_busy` bit is set in t+1.
- Step size is valid from `frequency_rom` in t+2; the first non-silent sample follows the next `generate_next_sample` after that.
- Voice loaded with D beats → `note_done` is high in the cycle after the D-th subsequent qualifying beat. `voice_busy` clears in the same cycle.
- `sample_ready` = voice 0 `sample_ready` delayed 1 cycle. `sample_out` is valid in the same cycle as `sample_ready` and held until the next update.
- Reset asserted mid-note: all state clears at the next edge. No `note_done` pulse is produced for killed notes.

## Configuration
- `VOICE_STEAL_EN` defined:
  - When all voices are ACTIVE, a legal request steals the ACTIVE voice with the smallest `count` (lowest index on ties).
  - That voice reloads with the new note and duration and pulses `note_done` in the same cycle as `load_accepted`.
  - `load_dropped` is then only for `duration==0` or `play_enable=0`.
- `VOICE_STEAL_EN` undefined: full → `load_dropped`. Active voices are never disturbed.

## Test plan
- Reset, then load note 20 with duration 3 and drive 3 beats → voice 0 busy at t+1; `note_done[0]` after the 3rd beat; `voice_busy=0`.
- VOICES=3: load 4 notes back to back with duration 10 → voices 0, 1, 2 busy; 4th gives `load_dropped`, or with VOICE_STEAL_EN steals voice 0 and pulses `note_done[0]`.
- Load with `duration=0` → `load_dropped=1`, `voice_busy` unchanged.
- Load coincident with `beat` while voice 1 is at count 1 → new voice count = duration, no decrement; voice 1 `note_done` pulses; voice 1 is not allocated that cycle.
- Two voices on note 0 (rest) plus one tone; pulse `generate_next_sample` → `sample_out` equals the single tone's sample sign-extended; `sample_ready` one cycle after the reader's.
- `play_enable=0` for 5 beats mid-note, then reset during an active note → counts frozen, no pulses; after reset all outputs 0.
